flexka_sub_z1_z0_z2: RTL and testbench

Karatsuba middle-term correction stage. It sits directly downstream of `flexka_operand_merging`, after the sub-multiplications have produced Z0 = L_A·L_B, Z2 = H_A·H_B and Z1 = (L_A+H_A)·(L_B+H_B) in the input buffer RAM. It computes Z1 ← Z1 − Z0 − Z2 in place, as two limb-serial borrow-propagating passes over the same two-read/one-write buffer RAM port used by operand merging. It reports completion, and flags underflow, to the controller's `STATE_WAIT_SUB_Z1_Z0_Z2`.

---
 rtl/flexka_sub_z1_z0_z2.sv | 250 +++++++++++++++++++++++++
 tb/tb_flexka_sub_z1_z0_z2.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flexka_sub_z1_z0_z2.sv
// Karatsuba middle-term correction: Z1 <- Z1 - Z0 - Z2, in place,
// as two limb-serial borrow-propagating passes over the buffer RAM.
module flexka_sub_z1_z0_z2 #(
    parameter int FSIZE  = 64,
    parameter int SSIZE  = 16,
    parameter int AW     = 10,
    parameter int RD_LAT = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             sub_start,
    input  logic [SSIZE-1:0] z1_pos,
    input  logic [SSIZE-1:0] z0_pos,
    input  logic [SSIZE-1:0] z2_pos,
    input  logic [SSIZE-1:0] z1_size,
    input  logic [SSIZE-1:0] z0_size,
    input  logic [SSIZE-1:0] z2_size,
    output logic [AW-1:0]    raddr0,
    output logic [AW-1:0]    raddr1,
    output logic             rd_valid,
    input  logic [FSIZE-1:0] rdata0,
    input  logic [FSIZE-1:0] rdata1,
    output logic [AW-1:0]    waddr,
    output logic [FSIZE-1:0] wdata,
    output logic             wren,
    output logic             sub_done,
    output logic             sub_underflow,
    output logic             busy
);

    localparam int DW = $clog2(RD_LAT + 2);
    localparam int L  = RD_LAT - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PASS_A,
        S_DRAIN_A,
        S_PASS_B,
        S_DRAIN_B
    } state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic [SSIZE-1:0] r_idx;
    logic [SSIZE-1:0] w_idx_nx;
    logic [DW-1:0]    r_dcnt;
    logic [DW-1:0]    w_dcnt_nx;

    logic [SSIZE-1:0] r_z1_pos;
    logic [SSIZE-1:0] r_z0_pos;
    logic [SSIZE-1:0] r_z2_pos;
    logic [SSIZE-1:0] r_z1_size;
    logic [SSIZE-1:0] r_z0_size;
    logic [SSIZE-1:0] r_z2_size;

    logic             r_done;
    logic             r_uf;
    logic             r_uf_a;
    logic             r_borrow;

    logic             r_vld_d   [RD_LAT];
    logic             r_zero_d  [RD_LAT];
    logic             r_first_d [RD_LAT];
    logic [AW-1:0]    r_wa_d    [RD_LAT];

    logic             r_wren;
    logic [AW-1:0]    r_waddr;
    logic [FSIZE-1:0] r_wdata;

    logic             w_load;
    logic             w_rd;
    logic             w_set_done;
    logic             w_uf_val;
    logic             w_uf_cap;
    logic [SSIZE-1:0] w_sub_pos;
    logic [SSIZE-1:0] w_sub_size;
    logic [SSIZE-1:0] w_a0;
    logic [SSIZE-1:0] w_a1;
    logic             w_zero;
    logic             w_first;
    logic [FSIZE-1:0] w_sub;
    logic             w_bin;
    logic [FSIZE:0]   w_diff;
    logic             w_unused_hi;

    assign w_load     = (r_state == S_IDLE) && sub_start;
    assign w_sub_pos  = (r_state == S_PASS_B) ? r_z2_pos : r_z0_pos;
    assign w_sub_size = (r_state == S_PASS_B) ? r_z2_size : r_z0_size;
    assign w_a0       = r_z1_pos + r_idx;
    assign w_a1       = w_sub_pos + r_idx;
    assign w_zero     = (r_idx >= w_sub_size);
    assign w_first    = (r_idx == '0);
    assign w_unused_hi = ^{w_a0[SSIZE-1:AW], w_a1[SSIZE-1:AW]};

    assign rd_valid      = w_rd;
    assign raddr0        = w_rd ? w_a0[AW-1:0] : '0;
    assign raddr1        = w_rd ? w_a1[AW-1:0] : '0;
    assign wren          = r_wren;
    assign waddr         = r_waddr;
    assign wdata         = r_wdata;
    assign sub_done      = r_done;
    assign sub_underflow = r_uf;
    assign busy          = (r_state != S_IDLE);

    // State, limb index and drain counter registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_dcnt  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
            r_dcnt  <= w_dcnt_nx;
        end
    end

    // Pass sequencing: issue one limb per cycle, then drain RD_LAT+1 cycles
    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_dcnt_nx  = r_dcnt;
        w_rd       = 1'b0;
        w_set_done = 1'b0;
        w_uf_val   = 1'b0;
        w_uf_cap   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (sub_start) begin
                    w_state_nx = S_PASS_A;
                    w_idx_nx   = '0;
                end
            end
            S_PASS_A, S_PASS_B: begin
                if (r_z1_size == '0) begin
                    w_state_nx = S_IDLE;
                    w_set_done = 1'b1;
                end else begin
                    w_rd = 1'b1;
                    if (r_idx == r_z1_size - SSIZE'(1)) begin
                        w_state_nx = (r_state == S_PASS_A) ? S_DRAIN_A : S_DRAIN_B;
                        w_idx_nx   = '0;
                        w_dcnt_nx  = '0;
                    end else begin
                        w_idx_nx = r_idx + SSIZE'(1);
                    end
                end
            end
            S_DRAIN_A, S_DRAIN_B: begin
                if (r_dcnt == DW'(RD_LAT)) begin
                    if (r_state == S_DRAIN_A) begin
                        w_state_nx = S_PASS_B;
                        w_uf_cap   = 1'b1;
                    end else begin
                        w_state_nx = S_IDLE;
                        w_set_done = 1'b1;
                        w_uf_val   = r_uf_a | r_borrow;
                    end
                end else begin
                    w_dcnt_nx = r_dcnt + DW'(1);
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Operand descriptors are captured only when a start is accepted
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_z1_pos  <= '0;
            r_z0_pos  <= '0;
            r_z2_pos  <= '0;
            r_z1_size <= '0;
            r_z0_size <= '0;
            r_z2_size <= '0;
        end else if (w_load) begin
            r_z1_pos  <= z1_pos;
            r_z0_pos  <= z0_pos;
            r_z2_pos  <= z2_pos;
            r_z1_size <= z1_size;
            r_z0_size <= z0_size;
            r_z2_size <= z2_size;
        end
    end

    // Completion and underflow flags seen by the controller
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_done <= 1'b0;
            r_uf   <= 1'b0;
            r_uf_a <= 1'b0;
        end else begin
            if (w_load) begin
                r_done <= 1'b0;
                r_uf   <= 1'b0;
            end else if (w_set_done) begin
                r_done <= 1'b1;
                r_uf   <= w_uf_val;
            end
            if (w_uf_cap) begin
                r_uf_a <= r_borrow;
            end
        end
    end

    // Control bits travel alongside the RAM read latency
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < RD_LAT; k++) begin
                r_vld_d[k]   <= 1'b0;
                r_zero_d[k]  <= 1'b0;
                r_first_d[k] <= 1'b0;
                r_wa_d[k]    <= '0;
            end
        end else begin
            for (int k = RD_LAT - 1; k > 0; k--) begin
                r_vld_d[k]   <= r_vld_d[k-1];
                r_zero_d[k]  <= r_zero_d[k-1];
                r_first_d[k] <= r_first_d[k-1];
                r_wa_d[k]    <= r_wa_d[k-1];
            end
            r_vld_d[0]   <= w_rd;
            r_zero_d[0]  <= w_zero;
            r_first_d[0] <= w_first;
            r_wa_d[0]    <= w_a0[AW-1:0];
        end
    end

    assign w_sub  = r_zero_d[L] ? '0 : rdata1;
    assign w_bin  = r_first_d[L] ? 1'b0 : r_borrow;
    assign w_diff = {1'b0, rdata0} - {1'b0, w_sub} - {{FSIZE{1'b0}}, w_bin};

    // Register the limb difference and its borrow-out for the write port
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wren   <= 1'b0;
            r_waddr  <= '0;
            r_wdata  <= '0;
            r_borrow <= 1'b0;
        end else begin
            r_wren <= r_vld_d[L];
            if (r_vld_d[L]) begin
                r_waddr  <= r_wa_d[L];
                r_wdata  <= w_diff[FSIZE-1:0];
                r_borrow <= w_diff[FSIZE];
            end
        end
    end

endmodule

// File: tb/tb_flexka_sub_z1_z0_z2.sv
// Bench for flexka_sub_z1_z0_z2: RAM model, big-integer reference,
// per-cycle output compare plus directed literal checks.
module tb_flexka_sub_z1_z0_z2;

    localparam int FS  = 8;
    localparam int AWB = 4;
    localparam int RDL = 2;
    localparam int DEP = 16;

    logic             clk;
    logic             rstn;
    logic             sub_start;
    logic [15:0]      z1_pos, z0_pos, z2_pos;
    logic [15:0]      z1_size, z0_size, z2_size;
    logic [AWB-1:0]   raddr0, raddr1, waddr;
    logic             rd_valid, wren;
    logic [FS-1:0]    rdata0, rdata1, wdata;
    logic             sub_done, sub_underflow, busy;

    flexka_sub_z1_z0_z2 #(
        .FSIZE(FS), .SSIZE(16), .AW(AWB), .RD_LAT(RDL)
    ) dut (
        .clk(clk), .rstn(rstn), .sub_start(sub_start),
        .z1_pos(z1_pos), .z0_pos(z0_pos), .z2_pos(z2_pos),
        .z1_size(z1_size), .z0_size(z0_size), .z2_size(z2_size),
        .raddr0(raddr0), .raddr1(raddr1), .rd_valid(rd_valid),
        .rdata0(rdata0), .rdata1(rdata1),
        .waddr(waddr), .wdata(wdata), .wren(wren),
        .sub_done(sub_done), .sub_underflow(sub_underflow), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // buffer RAM: 2-cycle read latency, one write port, bench load port
    logic [FS-1:0]  mem [DEP];
    logic [FS-1:0]  q0a, q0b, q1a, q1b;
    logic           ld;
    logic [AWB-1:0] ld_a;
    logic [FS-1:0]  ld_d;
    always @(posedge clk) begin
        if (ld) mem[ld_a] <= ld_d;
        else if (wren) mem[waddr] <= wdata;
        q0a <= mem[raddr0];
        q0b <= q0a;
        q1a <= mem[raddr1];
        q1b <= q1a;
    end
    assign rdata0 = q0b;
    assign rdata1 = q1b;

    int n_tests = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // expected events, keyed by cycle
    logic [15:0] exp_w [int];
    logic [15:0] exp_r [int];
    bit  chk_en = 0;
    bit  ev_on = 0;
    int  ev_s, ev_t;
    bit  ev_uf;
    bit  pv_done = 0, pv_uf = 0;
    logic [63:0] m_rb;
    bit  m_uf;

    function automatic logic [63:0] limbs(input int p, input int cnt);
        logic [63:0] v = 0;
        for (int i = 0; i < cnt; i++)
            v = v | (64'(mem[(p + i) % DEP]) << (FS * i));
        return v;
    endfunction

    // per-cycle compare against the model
    initial begin
        logic eb, ed, eu;
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                eu = pv_uf;
                if (!ev_on || cyc <= ev_s) begin
                    eb = 0; ed = pv_done; eu = pv_uf;
                end else if (cyc < ev_t) begin
                    eb = 1; ed = 0;
                end else begin
                    eb = 0; ed = 1; eu = ev_uf;
                end
                chk("busy", busy, eb);
                chk("sub_done", sub_done, ed);
                if (ed) chk("sub_underflow", sub_underflow, eu);
                chk("rd_valid", rd_valid, exp_r.exists(cyc));
                if (exp_r.exists(cyc) && rd_valid) begin
                    e = exp_r[cyc];
                    chk("raddr0", raddr0, e[7:4]);
                    if (e[8]) chk("raddr1", raddr1, e[3:0]);
                end
                chk("wren", wren, exp_w.exists(cyc));
                if (exp_w.exists(cyc) && wren) begin
                    e = exp_w[cyc];
                    chk("waddr", waddr, e[11:8]);
                    chk("wdata", wdata, e[7:0]);
                end
            end
        end
    end

    // called at posedge+1 phase
    task automatic load(input int a, input logic [FS-1:0] d);
        ld = 1; ld_a = AWB'(a); ld_d = d;
        @(posedge clk); #1;
        ld = 0;
    endtask

    task automatic load_rand();
        for (int a = 0; a < DEP; a++) load(a, FS'($urandom));
    endtask

    task automatic run(input int p1, input int p0, input int p2, input int n,
                       input int n0, input int n2, input bit dup, output int s);
        logic [63:0] za, s0, s2, mask, ra, rb;
        bit ufa, ufb;
        int b0;
        s = cyc;
        mask = (n == 0) ? 64'd0 : ((64'd1 << (FS * n)) - 1);
        za = limbs(p1, n);
        s0 = limbs(p0, n0);
        s2 = limbs(p2, n2);
        ra = (za - s0) & mask;
        ufa = (n != 0) && (za < s0);
        rb = (ra - s2) & mask;
        ufb = (n != 0) && (ra < s2);
        m_rb = rb;
        m_uf = ufa | ufb;
        if (ev_on) begin
            pv_done = 1; pv_uf = ev_uf;
        end
        ev_on = 1; ev_s = s; ev_uf = m_uf;
        ev_t = (n == 0) ? s + 2 : s + 2 * n + 2 * RDL + 3;
        b0 = s + n + RDL + 2;
        for (int i = 0; i < n; i++) begin
            exp_r[s + 1 + i] = {7'd0, i < n0, 4'((p1 + i) % DEP), 4'((p0 + i) % DEP)};
            exp_r[b0 + i]    = {7'd0, i < n2, 4'((p1 + i) % DEP), 4'((p2 + i) % DEP)};
            exp_w[s + 1 + i + RDL + 1] = {4'd0, 4'((p1 + i) % DEP), 8'(ra >> (FS * i))};
            exp_w[b0 + i + RDL + 1]    = {4'd0, 4'((p1 + i) % DEP), 8'(rb >> (FS * i))};
        end
        z1_pos = 16'(p1); z0_pos = 16'(p0); z2_pos = 16'(p2);
        z1_size = 16'(n); z0_size = 16'(n0); z2_size = 16'(n2);
        sub_start = 1;
        @(posedge clk); #1;
        if (dup) begin
            z1_size = 16'd3; z0_size = 16'd1; z2_size = 16'd1;
            @(posedge clk); #1;
        end
        sub_start = 0;
    endtask

    task automatic wait_done(input int s, input int off, input string nm);
        int t = -1;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (sub_done === 1'b1) begin
                t = cyc;
                break;
            end
        end
        chk(nm, t - s, off);
        @(posedge clk); #1;
    endtask

    task automatic chk_mem(input int p1, input int n, input string nm);
        for (int i = 0; i < n; i++)
            chk(nm, mem[(p1 + i) % DEP], 8'(m_rb >> (FS * i)));
    endtask

    int s, n, n0, n2, p1;

    initial begin
        rstn = 1; sub_start = 0; ld = 0; ld_a = '0; ld_d = '0;
        z1_pos = '0; z0_pos = '0; z2_pos = '0;
        z1_size = '0; z0_size = '0; z2_size = '0;
        #3 rstn = 0;
        #1;
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_wren", wren, 0);
        chk("rst_sub_done", sub_done, 0);
        chk("rst_uf", sub_underflow, 0);
        chk("rst_busy", busy, 0);
        chk("rst_raddr0", raddr0, 0);
        chk("rst_raddr1", raddr1, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_wdata", wdata, 0);
        repeat (3) @(posedge clk);
        #1 rstn = 1;
        load_rand();
        chk_en = 1;

        // directed: Z1={10,00,01} Z0={01,00} Z2={02}
        load(0, 8'h10); load(1, 8'h00); load(2, 8'h01);
        load(3, 8'h01); load(4, 8'h00); load(5, 8'h02);
        run(0, 3, 5, 3, 2, 1, 0, s);
        wait_done(s, 13, "t1_done_time");
        chk("t1_z1_0", mem[0], 8'h0D);
        chk("t1_z1_1", mem[1], 8'h00);
        chk("t1_z1_2", mem[2], 8'h01);
        chk("t1_uf", sub_underflow, 0);

        // borrow ripple
        load(8, 8'h00); load(9, 8'h00); load(10, 8'h01);
        load(11, 8'h01); load(12, 8'h00);
        run(8, 11, 12, 3, 1, 1, 0, s);
        wait_done(s, 13, "t2_done_time");
        chk("t2_z1_0", mem[8], 8'hFF);
        chk("t2_z1_1", mem[9], 8'hFF);
        chk("t2_z1_2", mem[10], 8'h00);
        chk("t2_uf", sub_underflow, 0);

        // underflow
        load(1, 8'h01); load(2, 8'h02); load(3, 8'h00);
        run(1, 2, 3, 1, 1, 1, 0, s);
        wait_done(s, 9, "t3_done_time");
        chk("t3_z1_0", mem[1], 8'hFF);
        chk("t3_uf", sub_underflow, 1);

        // empty Z1, with a second start while busy
        run(4, 6, 8, 0, 0, 0, 1, s);
        wait_done(s, 2, "t4_done_time");
        chk("t4_uf", sub_underflow, 0);
        repeat (10) @(posedge clk);
        #1;

        // address wrap
        load_rand();
        run(14, 2, 5, 3, 2, 3, 0, s);
        wait_done(s, 13, "t5_done_time");
        chk_mem(14, 3, "t5_z1");

        // reset in the middle of pass B
        load_rand();
        run(0, 4, 8, 4, 4, 4, 0, s);
        repeat (8) @(posedge clk);
        #1;
        rstn = 0;
        ev_on = 0; pv_done = 0; pv_uf = 0;
        exp_w.delete();
        exp_r.delete();
        #1;
        chk("mid_rst_wren", wren, 0);
        chk("mid_rst_rd_valid", rd_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_raddr0", raddr0, 0);
        chk("mid_rst_waddr", waddr, 0);
        chk("mid_rst_wdata", wdata, 0);
        repeat (2) @(posedge clk);
        #1 rstn = 1;
        repeat (8) @(posedge clk);
        #1;
        run(3, 9, 12, 3, 3, 2, 0, s);
        wait_done(s, 13, "t6_done_time");
        chk_mem(3, 3, "t6_z1");
        chk("t6_uf", sub_underflow, m_uf);

        // randomized runs
        for (int r = 0; r < 20; r++) begin
            load_rand();
            n = $urandom_range(1, 5);
            n0 = $urandom_range(0, n);
            n2 = $urandom_range(0, n);
            p1 = $urandom_range(0, DEP - 1);
            run(p1, (p1 + n) % DEP, (p1 + n + n0) % DEP, n, n0, n2, 0, s);
            wait_done(s, 2 * n + 2 * RDL + 3, "rnd_done_time");
            chk_mem(p1, n, "rnd_z1");
            chk("rnd_uf", sub_underflow, m_uf);
        end

        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
